// File: rtl/microtile_stim_sequencer.sv
// Clocked stimulus/response wrapper for a combinational microtile: applies LFSR vectors,
// waits SETTLE_CYCLES, folds uo_out into an 8-bit MISR. Define STIM_EXHAUSTIVE_EN for a 00..FF sweep.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | after reset, waiting for start
// S_SETTLE | vector on ui_in_o, counting down the tile settle time
// S_SAMPLE | one cycle: fold uo_out_i into MISR, advance the vector source
// S_DONE   | run complete, results held; start begins a new run directly
module microtile_stim_sequencer #(
    parameter int unsigned NUM_VECTORS   = 16,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  SEED          = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] uo_out_i,
    output logic [7:0] ui_in_o,
    output logic       busy,
    output logic       done,
    output logic [7:0] signature,
`ifdef STIM_EXHAUSTIVE_EN
    output logic [8:0] vec_count
`else
    output logic [7:0] vec_count
`endif
);

`ifdef STIM_EXHAUSTIVE_EN
    localparam int unsigned VCW       = 9;
    localparam int unsigned RUN_LEN   = 256;
    localparam logic [7:0]  FIRST_VEC = 8'h00;
`else
    localparam int unsigned VCW       = 8;
    localparam int unsigned RUN_LEN   = NUM_VECTORS;
    localparam logic [7:0]  FIRST_VEC = SEED;
`endif

    localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);

    if (SEED == 8'h00 || NUM_VECTORS < 1 || NUM_VECTORS > 255 ||
        SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_param_check
        $error("microtile_stim_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [7:0]       ui_q;
    logic [7:0]       lfsr_q;
    logic [7:0]       lfsr_d;
    logic [7:0]       misr_q;
    logic [7:0]       misr_d;
    logic [VCW-1:0]   vc_q;
    logic [3:0]       settle_q;
    logic             busy_q;
    logic             done_q;
    logic             last_vec;

`ifdef STIM_EXHAUSTIVE_EN
    assign lfsr_d = lfsr_q + 8'd1;
`else
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif

    assign misr_d   = {misr_q[6:0], misr_q[7] ^ misr_q[5] ^ misr_q[4] ^ misr_q[3]} ^ uo_out_i;
    assign last_vec = (vc_q == VCW'(RUN_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ui_q     <= 8'h00;
            lfsr_q   <= FIRST_VEC;
            misr_q   <= 8'h00;
            vc_q     <= '0;
            settle_q <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        ui_q     <= FIRST_VEC;
                        lfsr_q   <= FIRST_VEC;
                        misr_q   <= 8'h00;
                        vc_q     <= '0;
                        settle_q <= SETTLE_RELOAD;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        state_q  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == 4'd0) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    misr_q <= misr_d;
                    vc_q   <= vc_q + 1'b1;
                    lfsr_q <= lfsr_d;
                    if (last_vec) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        // next vector goes out together with the source advance
                        ui_q     <= lfsr_d;
                        settle_q <= SETTLE_RELOAD;
                        state_q  <= S_SETTLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ui_in_o   = ui_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = misr_q;
    assign vec_count = vc_q;

endmodule

// File: tb/tb_microtile_stim_sequencer.sv
// Bench for microtile_stim_sequencer: two instances with different lengths/settle times,
// randomized tile responses checked against a vector-list / MISR reference model.
`timescale 1ns/1ps
module tb_microtile_stim_sequencer;

`ifdef STIM_EXHAUSTIVE_EN
    localparam int VCW = 9;
    localparam int LEN_A = 256;
    localparam int LEN_B = 256;
    localparam logic [7:0] FIRST = 8'h00;
`else
    localparam int VCW = 8;
    localparam int LEN_A = 5;
    localparam int LEN_B = 2;
    localparam logic [7:0] FIRST = 8'h01;
`endif
    localparam int SC_A = 2;
    localparam int SC_B = 1;

    logic           clk;
    logic           rst_n;
    logic           start_a, start_b;
    logic [7:0]     uo_a, uo_b;
    logic [7:0]     ui_a, ui_b, sig_a, sig_b;
    logic           busy_a, busy_b, done_a, done_b;
    logic [VCW-1:0] vc_a, vc_b;

    logic           sel;
    logic [7:0]     ui_s, sig_s;
    logic           busy_s, done_s;
    logic [VCW-1:0] vc_s;

    int passed;
    int total;

    microtile_stim_sequencer #(.NUM_VECTORS(5), .SETTLE_CYCLES(SC_A), .SEED(8'h01)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .uo_out_i(uo_a), .ui_in_o(ui_a),
        .busy(busy_a), .done(done_a), .signature(sig_a), .vec_count(vc_a));

    microtile_stim_sequencer #(.NUM_VECTORS(2), .SETTLE_CYCLES(SC_B), .SEED(8'h01)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .uo_out_i(uo_b), .ui_in_o(ui_b),
        .busy(busy_b), .done(done_b), .signature(sig_b), .vec_count(vc_b));

    assign ui_s   = sel ? ui_b   : ui_a;
    assign sig_s  = sel ? sig_b  : sig_a;
    assign busy_s = sel ? busy_b : busy_a;
    assign done_s = sel ? done_b : done_a;
    assign vc_s   = sel ? vc_b   : vc_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_next(input logic [7:0] v);
`ifdef STIM_EXHAUSTIVE_EN
        return v + 8'd1;
`else
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
`endif
    endfunction

    function automatic logic [7:0] misr_fold(input logic [7:0] m, input logic [7:0] r);
        return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ r;
    endfunction

    // stand-in for the combinational tile
    function automatic logic [7:0] tile(input logic [7:0] v, input logic [7:0] k);
        return {v[6:0], v[7]} ^ (v + k);
    endfunction

    task automatic set_start(input logic v);
        if (sel) start_b = v; else start_a = v;
    endtask

    task automatic set_uo(input logic [7:0] v);
        if (sel) uo_b = v; else uo_a = v;
    endtask

    // mode: 0 clean tile, 1 constant key, 2 random glitch off-sample, 3 stale value off-sample
    task automatic run_check(input string name, input int mode, input logic [7:0] key, input int pulse_at);
        int         len, per, j, o;
        logic [7:0] vecs[$];
        logic [7:0] v, exp_sig, drv;
        len = sel ? LEN_B : LEN_A;
        per = (sel ? SC_B : SC_A) + 1;
        v = FIRST;
        for (int i = 0; i < len; i++) begin
            vecs.push_back(v);
            v = model_next(v);
        end
        exp_sig = 8'h00;
        for (int i = 0; i < len; i++)
            exp_sig = misr_fold(exp_sig, (mode == 1) ? key : tile(vecs[i], key));

        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        for (int c = 0; c < len * per; c++) begin
            j = c / per;
            o = c % per;
            total++;
            if (ui_s !== vecs[j])
                $display("FAIL %s ui_in cyc=%0d got=%02h want=%02h", name, c, ui_s, vecs[j]);
            else passed++;
            total++;
            if ({busy_s, done_s, vc_s} !== {1'b1, 1'b0, VCW'(j)})
                $display("FAIL %s busy/done/vec_count cyc=%0d got=%b/%b/%0d want=1/0/%0d",
                         name, c, busy_s, done_s, vc_s, j);
            else passed++;
            if (mode == 1) drv = key;
            else if (o == per - 1) drv = tile(vecs[j], key);
            else if (mode == 2) drv = 8'($urandom);
            else if (mode == 3) drv = (j == 0) ? 8'h00 : tile(vecs[j-1], key);
            else drv = tile(vecs[j], key);
            set_uo(drv);
            set_start(c == pulse_at);
            @(posedge clk); #1;
        end
        set_start(1'b0);
        total++;
        if ({busy_s, done_s} !== 2'b01)
            $display("FAIL %s end busy/done got=%b/%b want=0/1", name, busy_s, done_s);
        else passed++;
        total++;
        if (vc_s !== VCW'(len))
            $display("FAIL %s end vec_count got=%0d want=%0d", name, vc_s, len);
        else passed++;
        total++;
        if (sig_s !== exp_sig)
            $display("FAIL %s signature got=%02h want=%02h", name, sig_s, exp_sig);
        else passed++;
        total++;
        if (ui_s !== vecs[len-1])
            $display("FAIL %s end ui_in got=%02h want=%02h", name, ui_s, vecs[len-1]);
        else passed++;
    endtask

    task automatic test_reset();
        total++;
        if ({ui_a, busy_a, done_a, sig_a, vc_a} !== {8'h00, 1'b0, 1'b0, 8'h00, {VCW{1'b0}}})
            $display("FAIL reset_a got ui=%02h busy=%b done=%b sig=%02h vc=%0d want 00/0/0/00/0",
                     ui_a, busy_a, done_a, sig_a, vc_a);
        else passed++;
        total++;
        if ({ui_b, busy_b, done_b, sig_b, vc_b} !== {8'h00, 1'b0, 1'b0, 8'h00, {VCW{1'b0}}})
            $display("FAIL reset_b got ui=%02h busy=%b done=%b sig=%02h vc=%0d want 00/0/0/00/0",
                     ui_b, busy_b, done_b, sig_b, vc_b);
        else passed++;
    endtask

    task automatic test_sequence();
        sel = 1'b0;
        run_check("sequence", 0, 8'($urandom), -1);
    endtask

    task automatic test_signature_const();
        sel = 1'b1;
        run_check("const_ff_b", 1, 8'hFF, -1);
`ifndef STIM_EXHAUSTIVE_EN
        total++;
        if (sig_b !== 8'h01) $display("FAIL const_ff_len2 got=%02h want=01", sig_b);
        else passed++;
`endif
        sel = 1'b0;
        run_check("const_00_a", 1, 8'h00, -1);
        run_check("const_ff_a", 1, 8'hFF, -1);
    endtask

    task automatic test_settle_timing();
        sel = 1'b1;
        run_check("settle_stale", 3, 8'($urandom), -1);
        run_check("settle_glitch", 2, 8'($urandom), -1);
    endtask

    task automatic test_handshake();
        sel = 1'b0;
        run_check("start_in_settle", 0, 8'($urandom), 1);
        run_check("start_in_sample", 0, 8'($urandom), SC_A);
    endtask

    task automatic test_back_to_back();
        logic [7:0] held_ui, held_sig;
        sel = 1'b0;
        run_check("b2b_first", 2, 8'($urandom), -1);
        held_ui  = ui_a;
        held_sig = sig_a;
        for (int i = 0; i < 3; i++) begin
            uo_a = 8'($urandom);
            @(posedge clk); #1;
            total++;
            if ({done_a, busy_a, ui_a, sig_a} !== {1'b1, 1'b0, held_ui, held_sig})
                $display("FAIL done_hold got done=%b busy=%b ui=%02h sig=%02h want 1/0/%02h/%02h",
                         done_a, busy_a, ui_a, sig_a, held_ui, held_sig);
            else passed++;
        end
        run_check("b2b_restart", 0, 8'($urandom), -1);
    endtask

    task automatic test_reset_mid_run();
        sel = 1'b0;
        uo_a = 8'hA5;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({ui_a, busy_a, done_a, sig_a, vc_a} !== {8'h00, 1'b0, 1'b0, 8'h00, {VCW{1'b0}}})
            $display("FAIL reset_mid_run got ui=%02h busy=%b done=%b sig=%02h vc=%0d want 00/0/0/00/0",
                     ui_a, busy_a, done_a, sig_a, vc_a);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({busy_a, done_a, ui_a} !== {1'b0, 1'b0, 8'h00})
            $display("FAIL reset_release_idle got busy=%b done=%b ui=%02h want 0/0/00", busy_a, done_a, ui_a);
        else passed++;
        run_check("after_reset", 0, 8'($urandom), -1);
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 4; r++) begin
            sel = 1'($urandom);
            run_check("random", ($urandom_range(0, 1) == 0) ? 0 : 2, 8'($urandom), -1);
        end
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        sel     = 1'b0;
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        uo_a    = 8'h00;
        uo_b    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_sequence();
        test_signature_const();
        test_settle_timing();
        test_handshake();
        test_back_to_back();
        test_reset_mid_run();
        test_random_runs();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
